mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port synchronous RAM.
// Every access takes exactly four cycles: IDLE (arbitrate), ISSUE (address
// and write strobe to the RAM), DATA (RAM read data returns) and RESP
// (ack pulse, rdata valid).
// Handshake: a requester raises req with its address/data stable and holds
// it until it sees a one-cycle ack. The access is committed once it is granted
// in IDLE and always finishes with an ack, even if req drops early. A req
// still high in the cycle after ack is taken as a new access. The CPU may
// read or write; the device only reads.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dev_req,
    input  logic [15:0] dev_addr,
    output logic        dev_ack,
    output logic [15:0] dev_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  dbg_state,
    output logic        dbg_owner,
    output logic [3:0]  dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DEV = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic [15:0] owner_addr;

    assign owner_addr     = (owner_q == OWNER_DEV) ? dev_addr : cpu_addr;
    assign mem_wdata      = cpu_wdata;
    assign dbg_state      = state_q;
    assign dbg_owner      = owner_q;
    assign dbg_starve_cnt = starve_q;

    // State, owner and starvation counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_CPU;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Next state, arbitration decision and RAM/ack outputs.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        mem_addr = 16'h0000;
        mem_we   = 1'b0;
        cpu_ack  = 1'b0;
        dev_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                // With the device not asking there is nothing to starve.
                if (!dev_req) starve_d = 4'd0;
                if (cpu_req || dev_req) begin
                    state_d = ISSUE;
                    if (dev_req && (!cpu_req || starve_q == STARVE_LIM)) begin
                        owner_d  = OWNER_DEV;
                        starve_d = 4'd0;
                    end else begin
                        owner_d = OWNER_CPU;
                        // The CPU just passed over a waiting device.
                        if (dev_req && starve_q != STARVE_LIM)
                            starve_d = starve_q + 4'd1;
                    end
                end
            end
            ISSUE: begin
                state_d  = DATA;
                mem_addr = owner_addr;
                mem_we   = (owner_q == OWNER_CPU) && cpu_we;
            end
            DATA: begin
                state_d  = RESP;
                mem_addr = owner_addr;
            end
            RESP: begin
                state_d = IDLE;
                cpu_ack = (owner_q == OWNER_CPU);
                dev_ack = (owner_q == OWNER_DEV);
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture RAM read data for the owner on the DATA->RESP edge; CPU writes
    // leave the CPU read register alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= 16'h0000;
            dev_rdata <= 16'h0000;
        end else if (state_q == DATA) begin
            if (owner_q == OWNER_DEV)
                dev_rdata <= mem_rdata;
            else if (!cpu_we)
                cpu_rdata <= mem_rdata;
        end
    end

endmodule
